// File: rtl/custom_timer_pkg.sv
// Shared types and sizing helpers for the countdown timer.
// No logic of its own; the divider width derives from the clock/tick ratio.
package custom_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } timer_state_e;

   localparam int unsigned EXPIRE_CNT_W = 16;

   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
      return clk_hz / tick_hz;
   endfunction

   function automatic int unsigned calc_presc_w(input int unsigned div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/custom_tick_prescaler.sv
// Clock divider: tick is combinational, high on the DIV-th running clock after a clear.
// No backpressure; run freezes the count, clear has priority over run.
module custom_tick_prescaler
   import custom_timer_pkg::*;
#(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int unsigned PW = calc_presc_w(DIV);

   logic [PW-1:0] cnt_q, cnt_d;

   assign tick = run && (cnt_q == PW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/custom_countdown_timer.sv
// PS-controlled countdown timer with sticky expiry irq and saturating expiry tally.
// All outputs registered; first decrement DIV clocks after start; no backpressure.
module custom_countdown_timer
   import custom_timer_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 84000000,
   parameter int unsigned TICK_HZ     = 1,
   parameter int unsigned WIDTH       = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH-1:0]        load_value,
   input  logic                    load_strobe,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    periodic,
   input  logic                    irq_ack,
   output logic [WIDTH-1:0]        remaining,
   output logic                    busy,
   output logic                    irq,
   output logic [EXPIRE_CNT_W-1:0] expire_count
);

   localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);

   timer_state_e            state_q, state_d;
   logic [WIDTH-1:0]        rem_q, rem_d;
   logic [WIDTH-1:0]        reload_q, reload_d;
   logic                    busy_q, busy_d;
   logic                    irq_q, irq_d;
   logic [EXPIRE_CNT_W-1:0] exp_cnt_q, exp_cnt_d;
   logic                    presc_run, presc_clr, tick;
   logic [WIDTH-1:0]        eff_rem;
   logic                    expired;

   // A stop arriving on a tick cycle wins: the prescaler freezes and no decrement happens.
   assign presc_run = (state_q == RUNNING) && !stop;
   assign eff_rem   = load_strobe ? load_value : rem_q;

   custom_tick_prescaler #(.DIV(DIV)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (presc_run),
      .clear (presc_clr),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      reload_d  = reload_q;
      irq_d     = irq_q;
      exp_cnt_d = exp_cnt_q;
      presc_clr = 1'b0;
      expired   = 1'b0;

      if (load_strobe) begin
         reload_d  = load_value;
         rem_d     = load_value;
         presc_clr = 1'b1;
      end

      case (state_q)
         RUNNING: begin
            if (stop) begin
               state_d = PAUSED;
            end else if (tick && !load_strobe) begin
               if (rem_q > WIDTH'(1)) begin
                  rem_d = rem_q - WIDTH'(1);
               end else begin
                  expired = 1'b1;
                  if (periodic && (reload_q != '0)) begin
                     rem_d = reload_q;
                  end else begin
                     rem_d   = '0;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: begin
            if (start && !stop && (eff_rem != '0)) begin
               state_d   = RUNNING;
               presc_clr = 1'b1;
            end
         end
      endcase

      if (irq_ack) begin
         irq_d = 1'b0;
      end
      if (expired) begin
         irq_d = 1'b1;
         if (exp_cnt_q != '1) begin
            exp_cnt_d = exp_cnt_q + EXPIRE_CNT_W'(1);
         end
      end

      busy_d = (state_d == RUNNING);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         reload_q  <= '0;
         busy_q    <= 1'b0;
         irq_q     <= 1'b0;
         exp_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         reload_q  <= reload_d;
         busy_q    <= busy_d;
         irq_q     <= irq_d;
         exp_cnt_q <= exp_cnt_d;
      end
   end

   assign remaining    = rem_q;
   assign busy         = busy_q;
   assign irq          = irq_q;
   assign expire_count = exp_cnt_q;

endmodule
